exc_ctrl: RTL and testbench

Exception/interrupt controller at the MEM/WB boundary of the five-stage core. It turns the MEM-stage exception flags and the live CP0 state into the registered `excepttype`, faulting PC and delay-slot information that CP0 commits. It also drives the pipeline-wide flush and the redirect PC, which is either the exception vector or EPC for `eret`. It is the producer side of the CP0 exception interface.

---
 rtl/cpu_defs_pkg.sv | 38 +++
 rtl/exc_ctrl_bypass.sv | 35 +++
 rtl/exc_ctrl.sv | 129 ++++++++++++
 tb/tb_exc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: exception codes, CP0 addresses, status fields and
// the exception controller state encoding.
package cpu_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] EXC_NONE = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_INT  = 32'h0000_0001;
  localparam logic [XLEN-1:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [XLEN-1:0] EXC_RI   = 32'h0000_000a;
  localparam logic [XLEN-1:0] EXC_OV   = 32'h0000_000c;
  localparam logic [XLEN-1:0] EXC_TR   = 32'h0000_000d;
  localparam logic [XLEN-1:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned IM_LSB     = 8;
  localparam int unsigned IM_MSB     = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMMIT  = 2'd1,
    ST_RECOVER = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic            flush;
    logic [XLEN-1:0] excepttype;
    logic [XLEN-1:0] inst_addr;
    logic            in_delayslot;
    logic [XLEN-1:0] new_pc;
  } exc_out_t;

endpackage

// File: rtl/exc_ctrl_bypass.sv
// Combinational CP0 status/cause/EPC view with a WB-stage mtc0 overlaid;
// shared with the EX stage for mfc0 forwarding.
module cp0_bypass
  import cpu_defs::*;
(
  input  logic [XLEN-1:0] i_status,
  input  logic [XLEN-1:0] i_cause,
  input  logic [XLEN-1:0] i_epc,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_waddr,
  input  logic [XLEN-1:0] i_wb_wdata,
  output logic [XLEN-1:0] o_status_c,
  output logic [XLEN-1:0] o_cause_c,
  output logic [XLEN-1:0] o_epc_c
);

  always_comb begin
    o_status_c = i_status;
    o_cause_c  = i_cause;
    o_epc_c    = i_epc;
    if (i_wb_we) begin
      unique case (i_wb_waddr)
        CP0_REG_STATUS: o_status_c = i_wb_wdata;
        // Only the software interrupt bits and IV/WP are writable in cause
        CP0_REG_CAUSE: begin
          o_cause_c[9:8]   = i_wb_wdata[9:8];
          o_cause_c[23:22] = i_wb_wdata[23:22];
        end
        CP0_REG_EPC:    o_epc_c = i_wb_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM/WB exception and interrupt controller: prioritises exceptions, drives
// the CP0 commit payload, the pipeline flush and the redirect PC.
module exc_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic        is_syscall_i,
  input  logic        is_inv_inst_i,
  input  logic        is_trap_i,
  input  logic        is_ov_i,
  input  logic        is_eret_i,
  input  logic        stall_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] inst_addr_o,
  output logic        in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RECOVER_CYCLES - 1);

  exc_state_e       r_state;
  exc_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  exc_out_t         r_out;
  exc_out_t         w_out_next;

  logic [XLEN-1:0] w_status;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_epc;
  logic            w_int_pending;
  logic [XLEN-1:0] w_code;
  logic            w_candidate;
  logic            w_unused_c;

  cp0_bypass u_bypass (
    .i_status   (cp0_status_i),
    .i_cause    (cp0_cause_i),
    .i_epc      (cp0_epc_i),
    .i_wb_we    (wb_cp0_we_i),
    .i_wb_waddr (wb_cp0_waddr_i),
    .i_wb_wdata (wb_cp0_wdata_i),
    .o_status_c (w_status),
    .o_cause_c  (w_cause),
    .o_epc_c    (w_epc)
  );

  assign w_unused_c = ^{w_status[31:16], w_status[7:2], w_cause[31:16], w_cause[7:0]};

  assign w_int_pending = (|(w_cause[IM_MSB:IM_LSB] & w_status[IM_MSB:IM_LSB]))
                       && w_status[STATUS_IE] && !w_status[STATUS_EXL];

  // Priority encoder; eret loses to every other flag
  always_comb begin
    w_code = EXC_NONE;
    if (w_int_pending)      w_code = EXC_INT;
    else if (is_syscall_i)  w_code = EXC_SYS;
    else if (is_inv_inst_i) w_code = EXC_RI;
    else if (is_trap_i)     w_code = EXC_TR;
    else if (is_ov_i)       w_code = EXC_OV;
    else if (is_eret_i)     w_code = EXC_ERET;
  end

  assign w_candidate = inst_valid_i && !stall_i && (w_code != EXC_NONE);

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_out   <= w_out_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      ST_IDLE:   if (w_candidate) w_next_state = ST_COMMIT;
      ST_COMMIT: begin
        w_next_state = ST_RECOVER;
        w_cnt_next   = CNT_LOAD;
      end
      ST_RECOVER: begin
        if (r_cnt == '0) w_next_state = ST_IDLE;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Payload captured at detection is what the COMMIT cycle presents
  always_comb begin
    w_out_next = '0;
    if (r_state == ST_IDLE && w_candidate) begin
      w_out_next.flush        = 1'b1;
      w_out_next.excepttype   = w_code;
      w_out_next.inst_addr    = inst_addr_i;
      w_out_next.in_delayslot = in_delayslot_i;
      w_out_next.new_pc       = (w_code == EXC_ERET) ? w_epc : EXC_VECTOR;
    end
  end

  assign flush_o        = r_out.flush;
  assign excepttype_o   = r_out.excepttype;
  assign inst_addr_o    = r_out.inst_addr;
  assign in_delayslot_o = r_out.in_delayslot;
  assign new_pc_o       = r_out.new_pc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-budget reference model.
module tb_exc_ctrl;

  localparam int unsigned RC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, in_delayslot_i;
  logic [31:0] inst_addr_i;
  logic        is_syscall_i, is_inv_inst_i, is_trap_i, is_ov_i, is_eret_i;
  logic        stall_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic [31:0] excepttype_o, inst_addr_o, new_pc_o;
  logic        in_delayslot_o, flush_o;

  int n_vec = 0;
  int n_err = 0;

  int          m_busy;
  logic [97:0] m_exp;

  exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .in_delayslot_i(in_delayslot_i),
    .is_syscall_i(is_syscall_i), .is_inv_inst_i(is_inv_inst_i),
    .is_trap_i(is_trap_i), .is_ov_i(is_ov_i), .is_eret_i(is_eret_i),
    .stall_i(stall_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .excepttype_o(excepttype_o), .inst_addr_o(inst_addr_o),
    .in_delayslot_o(in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [97:0] ev(input logic f, input logic [31:0] t,
                                     input logic [31:0] a, input logic d,
                                     input logic [31:0] p);
    return {f, t, a, d, p};
  endfunction

  function automatic logic [97:0] got();
    return {flush_o, excepttype_o, inst_addr_o, in_delayslot_o, new_pc_o};
  endfunction

  // Reference: after an exception is taken, the next RC+1 cycles are blind.
  task automatic model_step();
    logic [31:0] st, ca, epc, code;
    bit pend;
    st = cp0_status_i; ca = cp0_cause_i; epc = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_wdata_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
      ca[9:8] = wb_cp0_wdata_i[9:8];
      ca[23:22] = wb_cp0_wdata_i[23:22];
    end
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) epc = wb_cp0_wdata_i;
    pend = ((ca[15:8] & st[15:8]) != 8'd0) && st[0] && !st[1];
    code = pend ? 32'h01 : is_syscall_i ? 32'h08 : is_inv_inst_i ? 32'h0a :
           is_trap_i ? 32'h0d : is_ov_i ? 32'h0c : is_eret_i ? 32'h0e : 32'h00;
    m_exp = '0;
    if (rst) begin
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (inst_valid_i && !stall_i && code != 32'h0) begin
      m_exp  = ev(1'b1, code, inst_addr_i, in_delayslot_i,
                  (code == 32'h0e) ? epc : 32'h20);
      m_busy = RC + 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; inst_valid_i = 1'b0; inst_addr_i = '0; in_delayslot_i = 1'b0;
    is_syscall_i = 1'b0; is_inv_inst_i = 1'b0; is_trap_i = 1'b0;
    is_ov_i = 1'b0; is_eret_i = 1'b0; stall_i = 1'b0;
    cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = '0; wb_cp0_wdata_i = '0;
  endtask

  task automatic settle();
    idle_inputs();
    repeat (RC + 3) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    n_vec++;
    if (got() !== ev(1'b0, 32'h0, 32'h0, 1'b0, 32'h0)) begin
      n_err++; $display("FAIL reset: got %h required %h", got(), ev(1'b0, 0, 0, 1'b0, 0));
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_syscall();
    logic [97:0] e;
    settle();
    inst_valid_i = 1'b1; inst_addr_i = 32'h100; is_syscall_i = 1'b1;
    tick();
    e = ev(1'b1, 32'h08, 32'h100, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL syscall: got %h required %h", got(), e); end
    idle_inputs();
    tick();
    n_vec++;
    if (got() !== '0) begin n_err++; $display("FAIL syscall_clear: got %h required 0", got()); end
  endtask

  task automatic test_interrupt();
    logic [97:0] e;
    settle();
    inst_valid_i = 1'b1; inst_addr_i = 32'h200; in_delayslot_i = 1'b1;
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    tick();
    e = ev(1'b1, 32'h01, 32'h200, 1'b1, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL interrupt: got %h required %h", got(), e); end
    settle();
    inst_valid_i = 1'b1; inst_addr_i = 32'h200; in_delayslot_i = 1'b1;
    cp0_status_i = 32'h0000_0403; cp0_cause_i = 32'h0000_0400;
    tick();
    n_vec++;
    if (got() !== '0) begin n_err++; $display("FAIL interrupt_exl: got %h required 0", got()); end
  endtask

  task automatic test_eret_bypass();
    logic [97:0] e;
    settle();
    inst_valid_i = 1'b1; inst_addr_i = 32'h500; is_eret_i = 1'b1;
    cp0_epc_i = 32'h300; wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h400;
    tick();
    e = ev(1'b1, 32'h0e, 32'h500, 1'b0, 32'h400);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL eret_bypass: got %h required %h", got(), e); end
    settle();
    inst_valid_i = 1'b1; inst_addr_i = 32'h504; is_eret_i = 1'b1; is_trap_i = 1'b1;
    tick();
    e = ev(1'b1, 32'h0d, 32'h504, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL eret_vs_trap: got %h required %h", got(), e); end
  endtask

  task automatic test_bypass_priority();
    logic [97:0] e;
    settle();
    inst_valid_i = 1'b1; inst_addr_i = 32'h700;
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h0;
    tick();
    n_vec++;
    if (got() !== '0) begin n_err++; $display("FAIL bypass_mask: got %h required 0", got()); end
    wb_cp0_we_i = 1'b0; is_ov_i = 1'b1;
    tick();
    e = ev(1'b1, 32'h01, 32'h700, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL int_over_ov: got %h required %h", got(), e); end
    settle();
    inst_valid_i = 1'b1; inst_addr_i = 32'h704; cp0_status_i = 32'h0000_0101;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h0000_0100;
    tick();
    e = ev(1'b1, 32'h01, 32'h704, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL cause_bypass: got %h required %h", got(), e); end
  endtask

  task automatic test_suppression();
    logic [97:0] e;
    settle();
    inst_valid_i = 1'b1; is_ov_i = 1'b1; inst_addr_i = 32'h600;
    tick();
    e = ev(1'b1, 32'h0c, 32'h600, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL ov_first: got %h required %h", got(), e); end
    inst_addr_i = 32'h604;
    tick();
    n_vec++;
    if (got() !== '0) begin n_err++; $display("FAIL ov_commit_ignored: got %h required 0", got()); end
    inst_addr_i = 32'h608;
    tick();
    n_vec++;
    if (got() !== '0) begin n_err++; $display("FAIL ov_recover_ignored: got %h required 0", got()); end
    inst_addr_i = 32'h60c;
    tick();
    e = ev(1'b1, 32'h0c, 32'h60c, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL ov_rearm: got %h required %h", got(), e); end
    settle();
    inst_valid_i = 1'b1; is_syscall_i = 1'b1; inst_addr_i = 32'h800; stall_i = 1'b1;
    repeat (3) begin
      tick();
      n_vec++;
      if (got() !== '0) begin n_err++; $display("FAIL stall_hold: got %h required 0", got()); end
    end
    stall_i = 1'b0;
    tick();
    e = ev(1'b1, 32'h08, 32'h800, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL stall_release: got %h required %h", got(), e); end
    idle_inputs();
    tick();
    n_vec++;
    if (got() !== '0) begin n_err++; $display("FAIL bubble_after: got %h required 0", got()); end
  endtask

  task automatic test_reset_in_commit();
    logic [97:0] e;
    settle();
    inst_valid_i = 1'b1; is_syscall_i = 1'b1; inst_addr_i = 32'h900;
    tick();
    e = ev(1'b1, 32'h08, 32'h900, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL pre_reset: got %h required %h", got(), e); end
    rst = 1'b1;
    tick();
    n_vec++;
    if (got() !== '0) begin n_err++; $display("FAIL reset_commit: got %h required 0", got()); end
    rst = 1'b0; inst_addr_i = 32'h904;
    tick();
    e = ev(1'b1, 32'h08, 32'h904, 1'b0, 32'h20);
    n_vec++;
    if (got() !== e) begin n_err++; $display("FAIL post_reset: got %h required %h", got(), e); end
  endtask

  task automatic test_random();
    int n_bad;
    logic [4:0] addrs [4];
    addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd3;
    n_bad = 0;
    settle();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(99) < 2);
      inst_valid_i   = ($urandom_range(9) < 8);
      inst_addr_i    = {$urandom} & 32'hffff_fffc;
      in_delayslot_i = $urandom_range(1) == 1;
      is_syscall_i   = ($urandom_range(19) == 0);
      is_inv_inst_i  = ($urandom_range(19) == 0);
      is_trap_i      = ($urandom_range(19) == 0);
      is_ov_i        = ($urandom_range(14) == 0);
      is_eret_i      = ($urandom_range(9) == 0);
      stall_i        = ($urandom_range(4) == 0);
      cp0_status_i   = $urandom;
      cp0_cause_i    = ($urandom_range(2) == 0) ? $urandom : 32'h0;
      cp0_epc_i      = $urandom;
      wb_cp0_we_i    = ($urandom_range(2) == 0);
      wb_cp0_waddr_i = addrs[$urandom_range(3)];
      wb_cp0_wdata_i = $urandom;
      tick();
      n_vec++;
      if (got() !== m_exp) begin
        n_err++;
        if (n_bad < 10) $display("FAIL random[%0d]: got %h required %h", i, got(), m_exp);
        n_bad++;
      end
    end
  endtask

  initial begin
    m_busy = 0;
    m_exp  = '0;
    idle_inputs();
    test_reset();
    test_syscall();
    test_interrupt();
    test_eret_bypass();
    test_bypass_priority();
    test_suppression();
    test_reset_in_commit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
